// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry
// and the helper that derives the address width from the register count.
package reg_file_mp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Address width for a power-of-two register count. A single register
  // still gets a 1-bit address so that port vectors keep a legal width.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int DEF_AW = addr_width(DEF_NREGS);

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundle of the register-file access signals. The master side (pipeline
// or bench) drives addresses, write data and busy marks; the slave side
// (register file) returns read data and busy flags.
//
// Handshake semantics: there is no valid/ready pairing. A write on port p
// is qualified only by wr_en[p], a busy mark only by busy_set; both are
// consumed on every rising clock edge they are high. Reads are always
// valid and combinational, so rd_data/busy follow rd_addr in the same cycle.
interface reg_file_mp_if #(
  parameter int XLEN  = reg_file_mp_pkg::DEF_XLEN,
  parameter int NREGS = reg_file_mp_pkg::DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();
  localparam int AW = reg_file_mp_pkg::addr_width(NREGS);

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                busy_set;
  logic [AW-1:0]       busy_addr;
  logic [NRD-1:0]      busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    input  rd_data, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    output rd_data, busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One read port: selects the addressed register and busy bit, optionally
// forwarding same-cycle write data, and forces register 0 to read as zero.
module reg_file_rd_port
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic [AW-1:0]              rd_addr_i,
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [NREGS-1:0]           busy_i,
  input  logic [NWR-1:0]             wr_en_i,
  input  logic [NWR*AW-1:0]          wr_addr_i,
  input  logic [NWR*XLEN-1:0]        wr_data_i,
  input  logic                       busy_set_i,
  input  logic [AW-1:0]              busy_addr_i,
  output logic [XLEN-1:0]            rd_data_o,
  output logic                       busy_o
);

  logic            hit;
  logic [XLEN-1:0] fwd_data;
  logic            is_zero;
  logic            set_same;

  // Decode the read address and apply forwarding; later write ports
  // overwrite earlier ones, so the highest-numbered matching port wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
        hit      = 1'b1;
        fwd_data = wr_data_i[p*XLEN +: XLEN];
      end
    end
    is_zero  = (ZERO_REG != 0) && (rd_addr_i == '0);
    set_same = busy_set_i && (busy_addr_i == rd_addr_i);

    rd_data_o = regs_i[rd_addr_i];
    busy_o    = busy_i[rd_addr_i];
    if ((BYPASS != 0) && hit) begin
      rd_data_o = fwd_data;
      // A retiring write hides the busy flag unless a new producer is
      // being marked on the same register in this very cycle.
      if (!set_same) busy_o = 1'b0;
    end
    if (is_zero) begin
      rd_data_o = '0;
      busy_o    = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy (scoreboard) bits,
// optional write-to-read forwarding and an optional hardwired zero register.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic                busy_set_i,
  input  logic [AW-1:0]       busy_addr_i,
  output logic [NRD-1:0]      busy_o
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [NRD*XLEN-1:0]        port_data;
  logic [NRD-1:0]             port_busy;

  // Next array and busy state: writes in ascending port order so the
  // highest port wins; clears from writes first, then the set, so a set
  // on the same register outranks the retiring write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p]) begin
        if (!((ZERO_REG != 0) && (wr_addr_i[p*AW +: AW] == '0))) begin
          regs_d[wr_addr_i[p*AW +: AW]] = wr_data_i[p*XLEN +: XLEN];
        end
        busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
    end
    if (busy_set_i && !((ZERO_REG != 0) && (busy_addr_i == '0))) begin
      busy_d[busy_addr_i] = 1'b1;
    end
  end

  // Array and busy state; reset clears everything regardless of the clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_rd_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rd_addr_i   (rd_addr_i[k*AW +: AW]),
      .regs_i      (regs_q),
      .busy_i      (busy_q),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .busy_set_i  (busy_set_i),
      .busy_addr_i (busy_addr_i),
      .rd_data_o   (port_data[k*XLEN +: XLEN]),
      .busy_o      (port_busy[k])
    );
  end

  // Forwarded write data would otherwise leak out while reset is held,
  // so outputs are forced to zero for the whole reset interval.
  always_comb begin
    rd_data_o = rst_n_i ? port_data : '0;
    busy_o    = rst_n_i ? port_busy : '0;
  end

endmodule
